// File: rtl/wb_fifo_uart_tx_pkg.sv
// Shared types and constants for the Wishbone-FIFO UART transmitter
// and its companion blocks (baud tick, future RX side).
package wb_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } uart_tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_fifo_uart_tx_if.sv
// Wishbone FIFO pop bus plus the FIFO empty flag. The UART TX block is
// the master (initiator); the FIFO side is the slave (responder).
interface wb_fifo_uart_tx_if #(
    parameter int DW = 8
);
    logic          wb_pop_stb;
    logic          wb_pop_cyc;
    logic [DW-1:0] wb_pop_data;
    logic          wb_pop_ack;
    logic          wb_pop_stall;
    logic          fifo_empty;

    modport master (
        output wb_pop_stb,
        output wb_pop_cyc,
        input  wb_pop_data,
        input  wb_pop_ack,
        input  wb_pop_stall,
        input  fifo_empty
    );

    modport slave (
        input  wb_pop_stb,
        input  wb_pop_cyc,
        output wb_pop_data,
        output wb_pop_ack,
        output wb_pop_stall,
        output fifo_empty
    );
endinterface

// File: rtl/wb_fifo_uart_tx_baud_tick.sv
// Bit-period timer: counts CLKS_PER_BIT cycles while enabled and flags
// the last cycle of each bit. Shared with the UART RX side.
module uart_baud_tick
    import wb_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_done
);
    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_bit_done = i_enable && (cnt_q == TERM);

    // Next count: clear wins, otherwise count up and wrap at the bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/wb_fifo_uart_tx.sv
// Pops one word at a time from the Wishbone FIFO and sends it on o_tx
// as an 8N1 frame (LSB first). Build option WB_FIFO_UART_TX_PARITY_EN
// adds an even-parity bit before the stop bit (8E1).
module wb_fifo_uart_tx
    import wb_uart_pkg::*;
#(
    parameter int DW           = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int ACK_TIMEOUT  = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    wb_fifo_uart_tx_if.master pop,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_timeout
);
    localparam int BW = cnt_w(DW);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
    // cyc is held ACK_TIMEOUT cycles counting the strobe cycle; the ack
    // slot right after the strobe always exists.
    localparam int WAIT_CYCLES = (ACK_TIMEOUT > 1) ? ACK_TIMEOUT - 1 : 1;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    uart_tx_state_t state_q, state_d;
    logic          stb_q, stb_d;
    logic          cyc_q, cyc_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
`ifdef WB_FIFO_UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif
    logic          baud_en;
    logic          bit_done;

    assign baud_en = (state_q == START) || (state_q == DATA) ||
                     (state_q == PARITY) || (state_q == STOP);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_clear    (!baud_en),
        .i_enable   (baud_en),
        .o_bit_done (bit_done)
    );

    assign pop.wb_pop_stb = stb_q;
    assign pop.wb_pop_cyc = cyc_q;
    assign o_tx           = tx_q;
    assign o_busy         = busy_q;
    assign o_timeout      = timeout_q;

    // Next-state and next-output logic for the pop / serialise sequence.
    always_comb begin
        state_d    = state_q;
        stb_d      = 1'b0;
        cyc_d      = cyc_q;
        tx_d       = tx_q;
        timeout_d  = 1'b0;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
`ifdef WB_FIFO_UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d  = LINE_IDLE;
                cyc_d = 1'b0;
                if (!pop.fifo_empty && !pop.wb_pop_stall) begin
                    state_d = REQ;
                    stb_d   = 1'b1;
                    cyc_d   = 1'b1;
                end
            end
            REQ: begin
                state_d    = WAIT;
                cyc_d      = 1'b1;
                wait_cnt_d = '0;
            end
            WAIT: begin
                if (pop.wb_pop_ack) begin
                    shift_d   = pop.wb_pop_data;
`ifdef WB_FIFO_UART_TX_PARITY_EN
                    parity_d  = ^pop.wb_pop_data;
`endif
                    cyc_d     = 1'b0;
                    bit_cnt_d = '0;
                    tx_d      = START_BIT;
                    state_d   = START;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    cyc_d     = 1'b0;
                    state_d   = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef WB_FIFO_UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = STOP_BIT;
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef WB_FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    tx_d    = STOP_BIT;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    tx_d    = LINE_IDLE;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = LINE_IDLE;
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset forces the line idle immediately.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            stb_q      <= 1'b0;
            cyc_q      <= 1'b0;
            tx_q       <= LINE_IDLE;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
`ifdef WB_FIFO_UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            stb_q      <= stb_d;
            cyc_q      <= cyc_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
`ifdef WB_FIFO_UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end
endmodule

// File: tb/tb_wb_fifo_uart_tx.sv
// Bench for wb_fifo_uart_tx with CLKS_PER_BIT=4, DW=8, ACK_TIMEOUT=4.
module tb_wb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef WB_FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] F55 = 11'h4AA, F01 = 11'h602, FFF = 11'h5FE,
                            FA5 = 11'h54A, F07 = 11'h60E;
`else
    localparam int NB = 10;
    localparam logic [10:0] F55 = 11'h2AA, F01 = 11'h202, FFF = 11'h3FE,
                            FA5 = 11'h34A, F07 = 11'h20E;
`endif

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        logic [10:0] frame;
        int          cyc;
        int          tmo;
    } vec_t;

    logic clk;
    logic rst_n;
    logic tx, busy, tmo;
    wb_fifo_uart_tx_if #(.DW(8)) bus ();

    wb_fifo_uart_tx #(
        .DW(8), .CLKS_PER_BIT(CPB), .ACK_TIMEOUT(4)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .pop(bus),
        .o_tx(tx), .o_busy(busy), .o_timeout(tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp, n_bad;
    logic [7:0] fifo_q[$];
    bit trace[$];
    int stb_tot, cyc_tot, busy_tot, to_tot, drops;
    int mode;   // 0: ack every strobe, 1: never ack and lose the word, 2: random drops
    bit pend;
    int t0, b_stb, b_cyc, b_busy, b_to, b_drop;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // FIFO responder: ack one cycle after a strobe, present the popped word.
    task automatic responder();
        bus.wb_pop_ack  = 1'b0;
        bus.wb_pop_data = '0;
        bus.fifo_empty  = 1'b1;
        pend = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.wb_pop_ack = 1'b0;
            if (!rst_n) pend = 1'b0;
            if (pend) begin
                pend = 1'b0;
                if (fifo_q.size() > 0) begin
                    bus.wb_pop_ack  = 1'b1;
                    bus.wb_pop_data = fifo_q.pop_front();
                end
            end
            if (bus.wb_pop_stb === 1'b1 && rst_n) begin
                case (mode)
                    0: pend = 1'b1;
                    1: fifo_q.delete();
                    default: if ($urandom_range(0, 3) == 0) drops++; else pend = 1'b1;
                endcase
            end
            bus.fifo_empty = (fifo_q.size() == 0);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            trace.push_back(tx);
            stb_tot  += int'(bus.wb_pop_stb);
            cyc_tot  += int'(bus.wb_pop_cyc);
            busy_tot += int'(busy);
            to_tot   += int'(tmo);
        end
    endtask

    task automatic watchdog();
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    endtask

    task automatic snap();
        t0 = trace.size(); b_stb = stb_tot; b_cyc = cyc_tot;
        b_busy = busy_tot; b_to = to_tot; b_drop = drops;
    endtask

    // Wait until the FIFO is drained and the block has been idle for 8 cycles.
    task automatic wait_idle(input int budget, input bit rnd_stall);
        int quiet = 0;
        int n = 0;
        while (quiet < 8 && n < budget) begin
            @(posedge clk);
            #1;
            if (rnd_stall) bus.wb_pop_stall = ($urandom_range(0, 3) == 0);
            if (!busy && !bus.wb_pop_stb && fifo_q.size() == 0) quiet++;
            else quiet = 0;
            n++;
        end
        bus.wb_pop_stall = 1'b0;
        if (quiet < 8) check("wait_idle_bound", n, -1);
    endtask

    // Expected line levels of one frame, index = bit time.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef WB_FIFO_UART_TX_PARITY_EN
        f[9]  = ^d;
        f[10] = 1'b1;
`else
        f[9]  = 1'b1;
`endif
        return f;
    endfunction

    function automatic int find_low(input int from);
        for (int i = from; i < trace.size(); i++) if (trace[i] == 1'b0) return i;
        return -1;
    endfunction

    // Reads NB bit times from the trace; ok=0 if a level is not held CPB cycles.
    function automatic logic [10:0] read_frame(input int s, output bit ok);
        logic [10:0] f = '0;
        ok = 1'b1;
        if (s < 0 || s + CPB * NB > trace.size()) begin
            ok = 1'b0;
            return f;
        end
        for (int b = 0; b < NB; b++) begin
            f[b] = trace[s + CPB * b];
            for (int j = 1; j < CPB; j++)
                if (trace[s + CPB * b + j] != f[b]) ok = 1'b0;
        end
        return f;
    endfunction

    initial begin
        vec_t tbl[6];
        logic [7:0] sent[$];
        logic [10:0] f;
        bit ok;
        int s, s2, idx, nfr;

        tbl[0] = '{8'h55, 1'b1, F55, 2, 0};
        tbl[1] = '{8'h01, 1'b1, F01, 2, 0};
        tbl[2] = '{8'hFF, 1'b1, FFF, 2, 0};
        tbl[3] = '{8'hA5, 1'b1, FA5, 2, 0};
        tbl[4] = '{8'h07, 1'b1, F07, 2, 0};
        tbl[5] = '{8'h3C, 1'b0, 11'h000, 4, 1};

        n_cmp = 0; n_bad = 0; mode = 0; drops = 0;
        stb_tot = 0; cyc_tot = 0; busy_tot = 0; to_tot = 0;
        rst_n = 1'b0;
        bus.wb_pop_stall = 1'b0;
        fork
            responder();
            monitor();
            watchdog();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", int'(tx), 1);
        check("rst_stb", int'(bus.wb_pop_stb), 0);
        check("rst_cyc", int'(bus.wb_pop_cyc), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_timeout", int'(tmo), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single-frame vectors
        for (int k = 0; k < 6; k++) begin
            mode = tbl[k].ack ? 0 : 1;
            snap();
            fifo_q.push_back(tbl[k].data);
            wait_idle(300, 1'b0);
            s = find_low(t0);
            check($sformatf("vec%0d_found", k), (s >= 0) ? 1 : 0, tbl[k].ack ? 1 : 0);
            if (s >= 0) begin
                f = read_frame(s, ok);
                check($sformatf("vec%0d_frame", k), int'(f), int'(tbl[k].frame));
                check($sformatf("vec%0d_hold", k), int'(ok), 1);
                check($sformatf("vec%0d_tail", k), find_low(s + CPB * NB), -1);
            end
            check($sformatf("vec%0d_stb", k), stb_tot - b_stb, 1);
            check($sformatf("vec%0d_cyc", k), cyc_tot - b_cyc, tbl[k].cyc);
            check($sformatf("vec%0d_timeout", k), to_tot - b_to, tbl[k].tmo);
            check($sformatf("vec%0d_busy", k), busy_tot - b_busy,
                  tbl[k].ack ? 2 + CPB * NB : 4);
        end
        mode = 0;

        // Back-to-back frames: 3-cycle high gap
        snap();
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'hFF);
        wait_idle(400, 1'b0);
        check("b2b_stb", stb_tot - b_stb, 2);
        s = find_low(t0);
        f = read_frame(s, ok);
        check("b2b_frame0", int'(f), int'(frame_of(8'h01)));
        s2 = find_low(s + CPB * NB);
        f = read_frame(s2, ok);
        check("b2b_frame1", int'(f), int'(frame_of(8'hFF)));
        check("b2b_gap", s2 - (s + CPB * NB), 3);

        // Empty FIFO for 100 cycles
        snap();
        repeat (100) @(posedge clk);
        #1;
        check("empty_stb", stb_tot - b_stb, 0);
        check("empty_busy", busy_tot - b_busy, 0);
        check("empty_line", find_low(t0), -1);

        // Stall while non-empty, then release
        bus.wb_pop_stall = 1'b1;
        snap();
        fifo_q.push_back(8'h5A);
        repeat (12) @(posedge clk);
        #1;
        check("stall_no_stb", stb_tot - b_stb, 0);
        bus.wb_pop_stall = 1'b0;
        check("stall_T_stb", int'(bus.wb_pop_stb), 0);
        @(posedge clk);
        #1;
        check("stall_T1_stb", int'(bus.wb_pop_stb), 1);
        wait_idle(300, 1'b0);
        f = read_frame(find_low(t0), ok);
        check("stall_frame", int'(f), int'(frame_of(8'h5A)));

        // Reset in DATA bit 3 of 0xA5
        fifo_q.push_back(8'hA5);
        s = 0;
        while (tx !== 1'b0 && s < 50) begin
            @(posedge clk);
            #1;
            s++;
        end
        check("mid_start_seen", int'(tx), 0);
        repeat (17) @(posedge clk);
        #1;
        check("mid_bit3_level", int'(tx), 0);
        #2;
        rst_n = 1'b0;
        fifo_q.delete();
        #1;
        check("mid_rst_tx", int'(tx), 1);
        check("mid_rst_stb", int'(bus.wb_pop_stb), 0);
        check("mid_rst_cyc", int'(bus.wb_pop_cyc), 0);
        check("mid_rst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        snap();
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_stb", stb_tot - b_stb, 0);
        check("post_rst_line", find_low(t0), -1);
        snap();
        fifo_q.push_back(8'h11);
        wait_idle(300, 1'b0);
        check("post_rst_stb1", stb_tot - b_stb, 1);
        f = read_frame(find_low(t0), ok);
        check("post_rst_frame", int'(f), int'(frame_of(8'h11)));

        // Randomised: random bytes, random stall, random lost acks
        mode = 2;
        snap();
        sent.delete();
        for (int i = 0; i < 8; i++) begin
            sent.push_back(8'($urandom_range(0, 255)));
            fifo_q.push_back(sent[i]);
        end
        wait_idle(6000, 1'b1);
        mode = 0;
        idx = t0;
        nfr = 0;
        s = find_low(idx);
        while (s >= 0 && nfr < 20) begin
            f = read_frame(s, ok);
            if (nfr < sent.size())
                check($sformatf("rnd_frame%0d", nfr), int'(f), int'(frame_of(sent[nfr])));
            check($sformatf("rnd_hold%0d", nfr), int'(ok), 1);
            nfr++;
            s = find_low(s + CPB * NB);
        end
        check("rnd_frames", nfr, 8);
        check("rnd_timeouts", to_tot - b_to, drops - b_drop);
        check("rnd_stb", stb_tot - b_stb, 8 + (drops - b_drop));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_fifo_uart_tx.md
Name: wb_fifo_uart_tx

Overview:
- Wishbone pop-side initiator that drains bytes from the team's Wishbone FIFO and serialises each one as an 8N1 UART frame on o_tx.
- Sits between the FIFO pop bus and the serial TX pin; the Z80 side pushes, this block pops.
- One pop request per frame; the next pop is issued only after the current frame's stop bit has completed.

Parameters:
- DW, 8, data word width; frame carries DW data bits, LSB first.
- CLKS_PER_BIT, 16, i_clk cycles per serial bit; legal range 2..65535.
- ACK_TIMEOUT, 4, cycles to wait for i_wb_pop_ack before abandoning a request; legal range 1..15.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset; one clock domain only.
- o_wb_pop_stb  out  1  pop strobe, single-cycle pulse.
- o_wb_pop_cyc  out  1  bus cycle; high from strobe until ack or timeout.
- i_wb_pop_data  in  DW  popped word; valid on the cycle i_wb_pop_ack=1.
- i_wb_pop_ack  in  1  pop acknowledge, one cycle after an accepted strobe.
- i_wb_pop_stall  in  1  responder stall; strobe is never issued while high.
- i_fifo_empty  in  1  FIFO empty flag.
- o_tx  out  1  serial line, idle high.
- o_busy  out  1  high in every state except IDLE.
- o_timeout  out  1  one-cycle pulse when a request is abandoned.

Behaviour:
- Reset (async assert): o_tx=1, o_wb_pop_stb=0, o_wb_pop_cyc=0, o_busy=0, o_timeout=0, state=IDLE, all counters 0. Applies immediately, including mid-frame; a partial frame is truncated with the line forced high.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: if !i_fifo_empty && !i_wb_pop_stall, go to REQ.
  - REQ: o_wb_pop_stb=1 and o_wb_pop_cyc=1 for exactly one cycle; go to WAIT.
  - WAIT: o_wb_pop_cyc=1, o_wb_pop_stb=0, count wait cycles.
    - On i_wb_pop_ack: latch i_wb_pop_data into the shift register, drop cyc, go to START.
    - If ACK_TIMEOUT cycles pass with no ack: pulse o_timeout, drop cyc, return to IDLE. No frame is sent.
  - START: o_tx=0 for CLKS_PER_BIT cycles.
  - DATA: shift out DW bits, LSB first, CLKS_PER_BIT cycles each; bit counter runs 0..DW-1.
  - (PARITY state exists only with the optional feature.)
  - STOP: o_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame latency:
  - Ack arrives on the cycle after REQ.
  - START begins the cycle after ack; o_tx falls on that edge.
  - Frame length is (DW+2)*CLKS_PER_BIT cycles; add CLKS_PER_BIT with parity.
- Back-to-back frames: IDLE→REQ→WAIT→ack adds a 3-cycle high gap between consecutive stop and start bits.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Reloads at every bit boundary; terminal count is CLKS_PER_BIT-1; wraps to 0.
- Ignored inputs:
  - A spurious ack outside WAIT is ignored.
  - i_fifo_empty and i_wb_pop_stall changes outside IDLE are ignored.
- Stall sampling: stall is checked only in IDLE; stall rising in REQ does not cancel the strobe, and the timeout covers a lost request.

Optional Feature:
- Macro: WB_FIFO_UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the DW data bits) is inserted between DATA and STOP for CLKS_PER_BIT cycles, giving 8E1.
- Undefined: no PARITY state, no parity logic; frame is 8N1.

Decomposition:
- Package wb_uart_pkg:
  - FSM state enum: IDLE, REQ, WAIT, START, DATA, PARITY, STOP.
  - Constants: line idle level (1'b1), start bit (1'b0), stop bit (1'b1).
  - Width helper function for the counters.
- Sub-module uart_baud_tick:
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clear and enable.
  - Output: bit_done pulse.
  - Reused later by the RX side.

Test Plan (CLKS_PER_BIT=4, DW=8, ACK_TIMEOUT=4):
- Reset mid-DATA bit 3 of 0xA5 → o_tx=1, stb=0, cyc=0 and o_busy=0 in the same cycle, before the next clock edge. No stb until the FIFO is non-empty after reset is released.
- FIFO holds 0x55, ack one cycle after stb → exactly one stb pulse. o_tx sequence: 0, 1,0,1,0,1,0,1,0, 1, each held 4 cycles, 40 cycles total.
- FIFO holds 0x01 then 0xFF → two stb pulses. Exactly 3 idle-high cycles between the first stop bit end and the second start bit.
- i_fifo_empty=1 for 100 cycles → no stb, o_tx constantly 1, o_busy=0.
- i_wb_pop_stall=1 while non-empty → no stb. Stall dropped at cycle T → stb asserted at T+1.
- No ack after stb → cyc high for 4 cycles, o_timeout pulses once, o_tx stays 1. With WB_FIFO_UART_TX_PARITY_EN, 0x07 gives parity bit 1 and a 44-cycle frame.
